// File: rtl/pll_mode_pkg.sv
// Shared types and constants for the PLL mode controller: FSM states, default
// timing parameters and the divider-select table for the four output modes.
package pll_mode_pkg;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_DEFAULT_MODE  = 0;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        STABLE,
        READY,
        FAULT
    } pll_state_e;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_sel_t;

    // Entries are already bit-inverted for the dynamic-select pins; static SEL
    // values are m0 {2,24,8}, m1 {0,10,4}, m2 {8,36,2}, m3 {26,53,16}.
    localparam logic [3:0][17:0] MODE_TABLE = {
        {6'd37, 6'd10, 6'd47},
        {6'd55, 6'd27, 6'd61},
        {6'd63, 6'd53, 6'd59},
        {6'd61, 6'd39, 6'd55}
    };

    function automatic pll_sel_t mode_sel(input logic [1:0] mode);
        return pll_sel_t'(MODE_TABLE[mode]);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the local clock
// domain; both stages clear on reset so the output starts low.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_mode_ctrl.sv
// PLL mode controller: programs the dynamic divider selects, sequences the
// PLL reset, waits for a stable lock and retries a bounded number of times.
module pll_mode_ctrl
    import pll_mode_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int DEFAULT_MODE  = DEF_DEFAULT_MODE
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    output logic [1:0] cur_mode,
    output logic       clk_ok,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    // The timer doubles as the reset-pulse counter, so it must fit either limit.
    localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int SW      = $clog2(STABLE_CYCLES + 1);

    pll_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] stb_q, stb_d;
    logic [1:0]    retry_q, retry_d;
    logic [1:0]    mode_q, mode_d;
    pll_sel_t      sel_q, sel_d;
    logic          clk_ok_q;
    logic          lock_s;
    logic          accept;
    logic          retry_path;

    sync_2ff u_lock_sync (
        .clk_i (clkin),
        .rst_i (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    assign accept = req_valid && req_ready;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q  <= RST_HOLD;
            tmr_q    <= '0;
            stb_q    <= '0;
            retry_q  <= '0;
            mode_q   <= 2'(DEFAULT_MODE);
            sel_q    <= mode_sel(2'(DEFAULT_MODE));
            clk_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            stb_q    <= stb_d;
            retry_q  <= retry_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            clk_ok_q <= (state_d == READY);
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        stb_d      = stb_q;
        retry_d    = retry_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        retry_path = 1'b0;

        case (state_q)
            RST_HOLD: begin
                if (tmr_q >= TW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                else                              tmr_d   = tmr_q + 1'b1;
            end
            WAIT_LOCK: begin
                if (lock_s)                              state_d    = STABLE;
                else if (tmr_q >= TW'(LOCK_TIMEOUT - 1)) retry_path = 1'b1;
                else                                     tmr_d      = tmr_q + 1'b1;
            end
            STABLE: begin
                // Any unlocked cycle restarts the run; the timeout keeps running.
                if (lock_s && stb_q >= SW'(STABLE_CYCLES - 1)) begin
                    state_d = READY;
                end else if (tmr_q >= TW'(LOCK_TIMEOUT - 1)) begin
                    retry_path = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    stb_d = lock_s ? stb_q + 1'b1 : '0;
                end
            end
            READY: begin
                if (!lock_s) retry_path = 1'b1;
            end
            FAULT: begin
            end
            default: state_d = RST_HOLD;
        endcase

        if (retry_path) begin
            if (retry_q < 2'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                state_d = RST_HOLD;
            end else begin
                state_d = FAULT;
            end
        end

        // A request overrides a simultaneous lock loss and starts a clean sequence.
        if (accept) begin
            mode_d  = req_mode;
            sel_d   = mode_sel(req_mode);
            retry_d = '0;
            state_d = RST_HOLD;
        end

        if (state_d != state_q) begin
            tmr_d = '0;
            stb_d = '0;
        end
    end

    always_comb begin
        pll_reset = (state_q == RST_HOLD) || (state_q == FAULT);
        req_ready = (state_q == READY) || (state_q == FAULT);
        fault     = (state_q == FAULT);
    end

    assign cur_mode  = mode_q;
    assign idsel     = sel_q.idsel;
    assign fbdsel    = sel_q.fbdsel;
    assign odsel     = sel_q.odsel;
    assign clk_ok    = clk_ok_q;
    assign retry_cnt = retry_q;

endmodule
